id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  Decode-to-execute pipeline stage downstream of the register file. Takes the
//  register file's two read ports plus decoded control and registers the EX operands.
//  Forwards results from EX/MEM and MEM/WB.
//  Detects load-use hazards; stalls IF/ID and injects a bubble.
//  Honours branch flush and a downstream hold.
// PARAMETERS
//  DW      32  datapath width (operands, forwarded data)
//  AW      5   register address width
//  ALUW    4   ALU opcode width
// PORTS
//  clk           in   1     rising-edge clock
//  reset_n       in   1     asynchronous active-low reset
//  i_valid       in   1     IF/ID holds a valid instruction
//  i_rs,i_rt     in   AW    source register addresses (same as regfile raddr1/raddr2)
//  i_rd          in   AW    destination register address
//  i_uses_rt     in   1     instruction reads rt (R-type, store, branch)
//  i_rdata1/2    in   DW    register file read data for rs/rt
//  i_imm         in   16    immediate field
//  i_imm_zext    in   1     1=zero-extend imm, 0=sign-extend
//  i_alu_src     in   1     1=opb from extended imm, 0=from rt value
//  i_alu_op      in   ALUW  ALU opcode
//  i_we,i_mem_rd,i_mem_wr in 1  regwrite / load / store controls
//  i_exmem_we    in   1     EX/MEM writes a register
//  i_exmem_waddr in   AW    EX/MEM destination
//  i_exmem_wdata in   DW    EX/MEM result
//  i_memwb_we/_waddr/_wdata  in 1/AW/DW  writeback port (also drives regfile)
//  i_flush       in   1     branch taken: kill instruction entering EX
//  i_hold        in   1     downstream busy: freeze this stage
//  o_stall       out  1     freeze PC and IF/ID this cycle
//  o_valid       out  1     EX instruction valid
//  o_opa,o_opb   out  DW    ALU operands
//  o_store_data  out  DW    forwarded rt value, for stores
//  o_waddr       out  AW    destination (i_rd)
//  o_alu_op      out  ALUW  registered ALU opcode
//  o_we,o_mem_rd,o_mem_wr  out 1  registered controls (0 whenever o_valid=0)
// BEHAVIOUR
//  - Reset (async, reset_n=0): all outputs 0; o_stall is combinational and reads 0.
//  - Latency: one cycle from ID inputs to registered outputs.
//  - Forward mux per source x in {rs, rt}, in priority order:
//    1. x==0 -> 0; r0 is never forwarded.
//    2. i_exmem_we & i_exmem_waddr==x -> i_exmem_wdata.
//    3. i_memwb_we & i_memwb_waddr==x -> i_memwb_wdata. This covers the
//       regfile same-edge write, whose read still returns the old value.
//    4. Otherwise i_rdata1/2.
//  - Immediate: imm_ext = i_imm_zext ? {16'b0,imm} : {{16{imm[15]}},imm}.
//    o_opb = i_alu_src ? imm_ext : fwd_rt.
//  - load_use = o_valid & o_mem_rd & o_waddr!=0
//    & (o_waddr==i_rs | (i_uses_rt & o_waddr==i_rt)).
//  - o_stall = i_hold | (i_valid & load_use & ~i_flush).
//  - Priority each edge:
//    1. i_hold: every register keeps its value; i_flush is ignored, and its
//       source must keep it asserted until i_hold drops.
//    2. i_flush: bubble (o_valid,o_we,o_mem_rd,o_mem_wr <= 0; data regs don't-care).
//    3. load_use stall: bubble, with IF/ID held.
//    4. Otherwise load inputs; o_valid <= i_valid, and controls are gated by i_valid.
//  - A bubble clears load_use next cycle, so a load-use costs exactly 1 stall cycle.
//  - reset_n low mid-stall: outputs clear immediately and o_stall drops.
// CONFIGURATION
//  ID_EX_FORWARD_EN defined: forwarding as above.
//  ID_EX_FORWARD_EN undefined:
//  - Operands come only from i_rdata1/2, with no forwarding.
//  - Stall condition widens to any RAW with EX, EX/MEM or MEM/WB on a used
//    source whose producer writes a nonzero register.
//  - This gives up to 3 stall cycles; the load_use term is subsumed.
// TESTING
//  1. Reset: reset_n=0 with i_valid=1 -> all outputs 0, o_stall=0.
//  2. EX/MEM forward: exmem writes r5=0x1234 and i_rs=5 (regfile 0xDEAD)
//     -> o_opa=0x1234 next cycle.
//  3. Double hit: exmem r3=0xA, memwb r3=0xB, i_rt=3
//     -> o_store_data=0xA (EX/MEM wins).
//  4. r0: exmem writes r0=0xFF and i_rs=0 -> o_opa=0.
//  5. Load-use:
//     - lw r7 in EX, then add using r7 -> o_stall=1 for 1 cycle and a bubble
//       (o_valid=0).
//     - Then the add issues with r7 taken from the memwb forward.
//  6. Imm and flush/hold:
//     - imm=0x8000 sign-extended -> o_opb=0xFFFF8000; zero-extended -> 0x00008000.
//     - i_flush -> o_valid=0.
//     - i_hold -> outputs unchanged and o_stall=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall and flush/hold control.
// Build with ID_EX_FORWARD_EN defined for forwarding; otherwise any RAW hazard stalls.
module id_ex_stage #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int ALUW = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_valid,
  input  logic [AW-1:0]   i_rs,
  input  logic [AW-1:0]   i_rt,
  input  logic [AW-1:0]   i_rd,
  input  logic            i_uses_rt,
  input  logic [DW-1:0]   i_rdata1,
  input  logic [DW-1:0]   i_rdata2,
  input  logic [15:0]     i_imm,
  input  logic            i_imm_zext,
  input  logic            i_alu_src,
  input  logic [ALUW-1:0] i_alu_op,
  input  logic            i_we,
  input  logic            i_mem_rd,
  input  logic            i_mem_wr,
  input  logic            i_exmem_we,
  input  logic [AW-1:0]   i_exmem_waddr,
  input  logic [DW-1:0]   i_exmem_wdata,
  input  logic            i_memwb_we,
  input  logic [AW-1:0]   i_memwb_waddr,
  input  logic [DW-1:0]   i_memwb_wdata,
  input  logic            i_flush,
  input  logic            i_hold,
  output logic            o_stall,
  output logic            o_valid,
  output logic [DW-1:0]   o_opa,
  output logic [DW-1:0]   o_opb,
  output logic [DW-1:0]   o_store_data,
  output logic [AW-1:0]   o_waddr,
  output logic [ALUW-1:0] o_alu_op,
  output logic            o_we,
  output logic            o_mem_rd,
  output logic            o_mem_wr
);

  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic [DW-1:0] imm_ext;
  logic          load_use;
  logic          hazard;
  logic          bubble;

  assign load_use = o_valid & o_mem_rd & (o_waddr != '0) &
                    ((o_waddr == i_rs) | (i_uses_rt & (o_waddr == i_rt)));

`ifdef ID_EX_FORWARD_EN
  // EX/MEM is the younger result, so it wins over MEM/WB; r0 is hardwired zero.
  always_comb begin
    fwd_rs = i_rdata1;
    if (i_rs == '0)
      fwd_rs = '0;
    else if (i_exmem_we && (i_exmem_waddr == i_rs))
      fwd_rs = i_exmem_wdata;
    else if (i_memwb_we && (i_memwb_waddr == i_rs))
      fwd_rs = i_memwb_wdata;

    fwd_rt = i_rdata2;
    if (i_rt == '0)
      fwd_rt = '0;
    else if (i_exmem_we && (i_exmem_waddr == i_rt))
      fwd_rt = i_exmem_wdata;
    else if (i_memwb_we && (i_memwb_waddr == i_rt))
      fwd_rt = i_memwb_wdata;
  end

  assign hazard = load_use;
`else
  logic raw_ex;
  logic raw_exmem;
  logic raw_memwb;
  logic unused_fwd_data;

  assign fwd_rs = i_rdata1;
  assign fwd_rt = i_rdata2;

  // Without forwarding, wait until every in-flight producer of a used source has retired.
  assign raw_ex    = o_valid & (o_we | o_mem_rd) & (o_waddr != '0) &
                     ((o_waddr == i_rs) | (i_uses_rt & (o_waddr == i_rt)));
  assign raw_exmem = i_exmem_we & (i_exmem_waddr != '0) &
                     ((i_exmem_waddr == i_rs) | (i_uses_rt & (i_exmem_waddr == i_rt)));
  assign raw_memwb = i_memwb_we & (i_memwb_waddr != '0) &
                     ((i_memwb_waddr == i_rs) | (i_uses_rt & (i_memwb_waddr == i_rt)));

  assign hazard          = load_use | raw_ex | raw_exmem | raw_memwb;
  assign unused_fwd_data = ^{i_exmem_wdata, i_memwb_wdata};
`endif

  assign imm_ext = i_imm_zext ? {{(DW-16){1'b0}}, i_imm} : {{(DW-16){i_imm[15]}}, i_imm};
  assign bubble  = i_flush | (i_valid & hazard);
  assign o_stall = i_hold | (i_valid & hazard & ~i_flush);

  // Hold freezes everything; a bubble only kills valid and controls, data regs are don't-care.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid      <= 1'b0;
      o_opa        <= '0;
      o_opb        <= '0;
      o_store_data <= '0;
      o_waddr      <= '0;
      o_alu_op     <= '0;
      o_we         <= 1'b0;
      o_mem_rd     <= 1'b0;
      o_mem_wr     <= 1'b0;
    end else if (!i_hold) begin
      if (bubble) begin
        o_valid  <= 1'b0;
        o_we     <= 1'b0;
        o_mem_rd <= 1'b0;
        o_mem_wr <= 1'b0;
      end else begin
        o_valid      <= i_valid;
        o_opa        <= fwd_rs;
        o_opb        <= i_alu_src ? imm_ext : fwd_rt;
        o_store_data <= fwd_rt;
        o_waddr      <= i_rd;
        o_alu_op     <= i_alu_op;
        o_we         <= i_valid & i_we;
        o_mem_rd     <= i_valid & i_mem_rd;
        o_mem_wr     <= i_valid & i_mem_wr;
      end
    end
  end

endmodule
